left_shifter_seq_n_bit: RTL

Multi-cycle logical left shifter for the ALU. It is the left-direction counterpart of the combinational N-bit right shifter.
- Shifts one bit position per clock.
- Uses a start/busy/done handshake.
- Reports the last bit shifted out of the MSB on cout.
- Intended for area-constrained builds where the barrel shifter is replaced by an iterative unit.

---
 rtl/left_shifter_seq_n_bit_pkg.sv | 16 +
 rtl/left_shifter_seq_n_bit_shift_step.sv | 25 ++
 rtl/left_shifter_seq_n_bit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/left_shifter_seq_n_bit_pkg.sv
// Shared types and helpers for the iterative left shifter: FSM state encoding
// and the step-counter width rule.
package left_shifter_seq_n_bit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One extra bit so the clamped step count N+1 always fits.
  function automatic int cnt_width(input int sw);
    return sw + 1;
  endfunction

endpackage

// File: rtl/left_shifter_seq_n_bit_shift_step.sv
// Single-position left shift (or rotate) of an N-bit word, reporting the bit
// that leaves the MSB as carry.
module shift_step_n_bit
  import left_shifter_seq_n_bit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         rotate,
  output logic [N-1:0] next,
  output logic         carry
);

  // Select the refill bit: old MSB when rotating, zero for a logical shift.
  always_comb begin
    next  = {N{1'b0}};
    carry = data[N-1];
    if (rotate) begin
      next = {data[N-2:0], data[N-1]};
    end else begin
      next = {data[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/left_shifter_seq_n_bit.sv
// Multi-cycle logical left shifter, one bit per clock, start/busy/done handshake.
// Optional rotate mode enabled by defining LEFT_SHIFTER_ROTATE_EN.
module left_shifter_seq_n_bit
  import left_shifter_seq_n_bit_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef LEFT_SHIFTER_ROTATE_EN
  input  logic          rotate,
`endif
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] shift,
  output logic [N-1:0]  out,
  output logic          cout,
  output logic          busy,
  output logic          done
);

  localparam int CW = cnt_width(SW);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e          state_r;
  logic [N-1:0]    work_r;
  logic            cout_r;
  logic            busy_r;
  logic            done_r;
  logic            rot_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   k_s;
  logic            rot_req_s;
  logic [N-1:0]    step_next_s;
  logic            step_carry_s;

`ifdef LEFT_SHIFTER_ROTATE_EN
  assign rot_req_s = rotate;
`else
  assign rot_req_s = 1'b0;
`endif

  // Step count: rotation wraps modulo N; logical shifts clamp at N+1 to bound latency.
  always_comb begin
    k_s = CNT_ZERO;
    if (rot_req_s) begin
      k_s = CW'(32'(shift) % 32'(N));
    end else if (32'(shift) > 32'(N)) begin
      k_s = CW'(N + 1);
    end else begin
      k_s = CW'(shift);
    end
  end

  shift_step_n_bit #(.N(N)) u_step (
    .data   (work_r),
    .rotate (rot_r),
    .next   (step_next_s),
    .carry  (step_carry_s)
  );

  // Control FSM with the work register, carry and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      work_r  <= {N{1'b0}};
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rot_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (start) begin
            work_r <= in_a;
            cout_r <= 1'b0;
            rot_r  <= rot_req_s;
            cnt_r  <= k_s;
            busy_r <= 1'b1;
            if (k_s == CNT_ZERO) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_r <= step_next_s;
          cout_r <= step_carry_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = work_r;
  assign cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
